seq_div64by32: RTL and testbench



---
 rtl/seq_div64by32_pkg.sv | 12 +
 rtl/seq_div64by32_iter_step.sv | 28 ++
 rtl/seq_div64by32.sv | 120 ++++++++++++
 tb/tb_seq_div64by32.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div64by32_pkg.sv
// rtl/seq_div64by32_pkg.sv - shared width default and FSM encoding for the sequential divider
package seq_div64by32_pkg;

   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_div64by32_iter_step.sv
// rtl/seq_div64by32_iter_step.sv - one combinational restoring-division step
module div_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             next_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   // rem_in is always below divisor, so whichever value is kept fits back into WIDTH bits
   always_comb begin
      trial = {rem_in, next_bit};
      diff  = trial - {1'b0, divisor};
      if (trial >= {1'b0, divisor}) begin
         rem_out = diff[WIDTH-1:0];
         q_bit   = 1'b1;
      end else begin
         rem_out = trial[WIDTH-1:0];
         q_bit   = 1'b0;
      end
   end

endmodule

// File: rtl/seq_div64by32.sv
// rtl/seq_div64by32.sv - signed 2W/W restoring divider, one quotient bit per clock
module seq_div64by32
   import seq_div64by32_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 dbz,
   output logic                 ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] NEG_LIMIT = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;   // low dividend bits shift out, quotient bits shift in
   logic [CW-1:0]    cnt;

   logic [2*WIDTH-1:0] abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH-1:0]   rem_next;
   logic               q_bit;
   logic               q_neg;
   logic               q_range_err;
   logic [WIDTH-1:0]   q_signed;
   logic [WIDTH-1:0]   r_signed;

   always_comb begin
      abs_a       = in_a[2*WIDTH-1] ? -in_a : in_a;
      abs_b       = in_b[WIDTH-1]   ? -in_b : in_b;
      q_neg       = sign_a ^ sign_b;
      q_range_err = q_neg ? (dvd > NEG_LIMIT) : dvd[WIDTH-1];
      q_signed    = q_neg  ? -dvd : dvd;
      r_signed    = sign_a ? -rem : rem;
   end

   div_iter_step #(.WIDTH(WIDTH)) u_step (
      .rem_in   (rem),
      .next_bit (dvd[WIDTH-1]),
      .divisor  (mag_b),
      .rem_out  (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         state     <= IDLE;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         mag_b     <= '0;
         rem       <= '0;
         dvd       <= '0;
         cnt       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         dbz       <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               if (start) begin
                  sign_a <= in_a[2*WIDTH-1];
                  sign_b <= in_b[WIDTH-1];
                  mag_b  <= abs_b;
                  rem    <= abs_a[2*WIDTH-1:WIDTH];
                  dvd    <= abs_a[WIDTH-1:0];
                  cnt    <= '0;
                  busy   <= 1'b1;
                  dbz    <= 1'b0;
                  ovf    <= 1'b0;
                  // a high half not below the divisor cannot give a WIDTH-bit quotient
                  if (in_b == '0) begin
                     dbz   <= 1'b1;
                     state <= FIX;
                  end else if (abs_a[2*WIDTH-1:WIDTH] >= abs_b) begin
                     ovf   <= 1'b1;
                     state <= FIX;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= rem_next;
               dvd <= {dvd[WIDTH-2:0], q_bit};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH-1)) state <= FIX;
            end
            FIX: begin
               out_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
               if (dbz || ovf) begin
                  out <= '0;
               end else if (q_range_err) begin
                  ovf <= 1'b1;
                  out <= '0;
               end else begin
                  out <= {r_signed, q_signed};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div64by32.sv
// tb/tb_seq_div64by32.sv - self-checking bench for seq_div64by32
module tb_seq_div64by32;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [63:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [63:0] out;
   logic        out_valid, busy, dbz, ovf;

   int n_pass = 0;
   int n_total = 0;

   always #5 CLK = ~CLK;

   seq_div64by32 dut (
      .CLK(CLK), .reset(reset), .start(start), .in_a(in_a), .in_b(in_b),
      .out(out), .out_valid(out_valid), .busy(busy), .dbz(dbz), .ovf(ovf)
   );

   // Reference: truncating signed division on magnitudes with the range rules of the block
   task automatic model(input logic [63:0] a, input logic [31:0] b,
                        output logic [63:0] o, output logic d, output logic v, output int lat);
      logic [63:0] ma, mb, qm, rm, q, r;
      logic        qneg;
      ma = a[63] ? -a : a;
      mb = {32'd0, (b[31] ? -b : b)};
      o = '0; d = 1'b0; v = 1'b0; lat = 33;
      if (mb == 0) begin
         d = 1'b1; lat = 1;
      end else if (ma >= (mb << 32)) begin
         v = 1'b1; lat = 1;
      end else begin
         qm = ma / mb;
         rm = ma % mb;
         qneg = a[63] ^ b[31];
         if (qneg ? (qm > 64'h8000_0000) : (qm > 64'h7FFF_FFFF)) begin
            v = 1'b1;
         end else begin
            q = qneg ? -qm : qm;
            r = a[63] ? -rm : rm;
            o = {r[31:0], q[31:0]};
         end
      end
   endtask

   task automatic do_div(input logic [63:0] a, input logic [31:0] b,
                         output logic [63:0] o, output logic d, output logic v,
                         output int lat, output int busy_n);
      @(negedge CLK);
      in_a = a; in_b = b; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      lat = 0; busy_n = 0;
      while (!out_valid && lat < 60) begin
         if (busy) busy_n++;
         @(posedge CLK); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      o = out; d = dbz; v = ovf;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      n_total++;
      if ({out, out_valid, busy, dbz, ovf} !== 68'd0) $display("FAIL reset_outputs got=%h req=0", {out, out_valid, busy, dbz, ovf});
      else n_pass++;
      @(negedge CLK); reset = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      n_total++;
      if ({out_valid, busy} !== 2'b00) $display("FAIL idle_after_reset got=%b req=00", {out_valid, busy});
      else n_pass++;
   endtask

   task automatic test_basic();
      logic [63:0] o; logic d, v; int lat, bn;
      do_div(64'd2700, 32'd90, o, d, v, lat, bn);
      n_total++;
      if (lat !== 33) $display("FAIL basic_latency got=%0d req=33", lat); else n_pass++;
      n_total++;
      if (bn !== 33) $display("FAIL basic_busy_cycles got=%0d req=33", bn); else n_pass++;
      n_total++;
      if ({o, d, v} !== {32'd0, 32'd30, 2'b00}) $display("FAIL basic_result got=%h d=%b v=%b req=%h", o, d, v, {32'd0, 32'd30});
      else n_pass++;
      @(posedge CLK); #1;
      n_total++;
      if ({out_valid, out} !== {1'b0, 32'd0, 32'd30}) $display("FAIL basic_pulse_hold got=%b/%h req=0/%h", out_valid, out, {32'd0, 32'd30});
      else n_pass++;
   endtask

   task automatic test_signs();
      longint ta[3] = '{-2705, 2705, -2705};
      int     tb_b[3] = '{90, -90, -90};
      int     eq[3] = '{-30, -30, 30};
      int     er[3] = '{-5, 5, -5};
      logic [63:0] o, e; logic d, v; int lat, bn;
      int q, r;
      for (int i = 0; i < 3; i++) begin
         do_div(ta[i], tb_b[i], o, d, v, lat, bn);
         q = eq[i]; r = er[i];
         e = {r[31:0], q[31:0]};
         n_total++;
         if ({o, d, v} !== {e, 2'b00} || lat !== 33)
            $display("FAIL sign_case%0d got=%h d=%b v=%b lat=%0d req=%h lat=33", i, o, d, v, lat, e);
         else n_pass++;
      end
   endtask

   task automatic test_dbz();
      logic [63:0] o; logic d, v; int lat, bn;
      do_div(64'd123, 32'd0, o, d, v, lat, bn);
      n_total++;
      if ({o, d, v} !== {64'd0, 2'b10} || lat !== 1) $display("FAIL dbz got=%h d=%b v=%b lat=%0d req=0 d=1 v=0 lat=1", o, d, v, lat);
      else n_pass++;
      do_div(64'd100, 32'd7, o, d, v, lat, bn);
      n_total++;
      if ({o, d, v} !== {32'd2, 32'd14, 2'b00} || lat !== 33) $display("FAIL after_dbz got=%h lat=%0d req=%h lat=33", o, lat, {32'd2, 32'd14});
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [63:0] o; logic d, v; int lat, bn;
      do_div(64'h100_0000_0000, 32'd1, o, d, v, lat, bn);
      n_total++;
      if ({o, d, v} !== {64'd0, 2'b01} || lat !== 1) $display("FAIL early_ovf got=%h d=%b v=%b lat=%0d req=0 v=1 lat=1", o, d, v, lat);
      else n_pass++;
      do_div(64'h8000_0000, 32'd1, o, d, v, lat, bn);
      n_total++;
      if ({o, d, v} !== {64'd0, 2'b01} || lat !== 33) $display("FAIL late_ovf got=%h d=%b v=%b lat=%0d req=0 v=1 lat=33", o, d, v, lat);
      else n_pass++;
      do_div(64'hFFFF_FFFF_8000_0000, 32'd1, o, d, v, lat, bn);
      n_total++;
      if ({o, d, v} !== {64'h0000_0000_8000_0000, 2'b00} || lat !== 33) $display("FAIL min_quotient got=%h d=%b v=%b lat=%0d req=0000000080000000", o, d, v, lat);
      else n_pass++;
      do_div(64'h8000_0000_0000_0000, 32'hFFFF_FFFF, o, d, v, lat, bn);
      n_total++;
      if ({o, d, v} !== {64'd0, 2'b01} || lat !== 1) $display("FAIL min_dividend got=%h v=%b lat=%0d req=0 v=1 lat=1", o, v, lat);
      else n_pass++;
   endtask

   task automatic test_roundtrip();
      logic [63:0] o, e, my, rm; logic d, v; int lat, bn;
      int x, y, rr, bad;
      longint prod, r64;
      do_div(-64'sd2700, -32'sd90, o, d, v, lat, bn);
      n_total++;
      if ({o, d, v} !== {32'd0, 32'd30, 2'b00}) $display("FAIL roundtrip_fixed got=%h req=%h", o, {32'd0, 32'd30});
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         x = $urandom;
         y = (i % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
         if (y == 0) y = 1;
         prod = longint'(x) * longint'(y);
         my = y < 0 ? -longint'(y) : longint'(y);
         rm = {$urandom, $urandom} % my;
         r64 = prod < 0 ? -longint'(rm) : longint'(rm);
         rr = int'(r64);
         e = {rr[31:0], x[31:0]};
         do_div(prod + r64, y, o, d, v, lat, bn);
         if ({o, d, v} !== {e, 2'b00} || lat !== 33) begin
            bad++;
            if (bad <= 5) $display("FAIL roundtrip x=%0d y=%0d got=%h d=%b v=%b lat=%0d req=%h", x, y, o, d, v, lat, e);
         end
      end
      n_total++;
      if (bad !== 0) $display("FAIL roundtrip_sweep got=%0d bad req=0", bad);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [63:0] o, eo; logic d, v, ed, ev; int lat, el, bn;
      logic signed [63:0] sa;
      logic [31:0] b;
      int bad;
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         sa = {$urandom, $urandom};
         sa = sa >>> $urandom_range(0, 40);
         b = (i % 7 == 0) ? 32'($urandom_range(0, 2)) : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 70000)));
         if (i % 3 == 0) b = -b;
         model(sa, b, eo, ed, ev, el);
         do_div(sa, b, o, d, v, lat, bn);
         if ({o, d, v} !== {eo, ed, ev} || lat !== el) begin
            bad++;
            if (bad <= 5) $display("FAIL random a=%h b=%h got=%h d=%b v=%b lat=%0d req=%h d=%b v=%b lat=%0d", sa, b, o, d, v, lat, eo, ed, ev, el);
         end
      end
      n_total++;
      if (bad !== 0) $display("FAIL random_sweep got=%0d bad req=0", bad);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] o1, o2, e1, e2; logic d1, v1, d2, v2, ed, ev; int l1, l2, el, bn;
      model(64'd1000001, 32'd3, e1, ed, ev, el);
      model(-64'sd77777777, 32'd1234, e2, ed, ev, el);
      do_div(64'd1000001, 32'd3, o1, d1, v1, l1, bn);
      do_div(-64'sd77777777, 32'd1234, o2, d2, v2, l2, bn);
      n_total++;
      if (o1 !== e1 || l1 !== 33) $display("FAIL b2b_first got=%h lat=%0d req=%h", o1, l1, e1); else n_pass++;
      n_total++;
      if (o2 !== e2 || l2 !== 33) $display("FAIL b2b_second got=%h lat=%0d req=%h", o2, l2, e2); else n_pass++;
   endtask

   task automatic test_ignore_start();
      logic [63:0] e; logic ed, ev; int el, lat, pulses;
      model(-64'sd987654321, 32'd12345, e, ed, ev, el);
      @(negedge CLK);
      in_a = -64'sd987654321; in_b = 32'd12345; start = 1'b1;
      @(posedge CLK); #1;
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(negedge CLK);
         if (lat == 9) begin start = 1'b1; in_a = 64'd5; in_b = 32'd1; end
         else start = 1'b0;
         @(posedge CLK); #1;
         lat++;
      end
      start = 1'b0;
      n_total++;
      if (out !== e || lat !== 33) $display("FAIL ignore_start got=%h lat=%0d req=%h lat=33", out, lat, e);
      else n_pass++;
      pulses = 0;
      repeat (40) begin @(posedge CLK); #1; if (out_valid) pulses++; end
      n_total++;
      if (pulses !== 0) $display("FAIL no_queued_op got=%0d pulses req=0", pulses); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [63:0] o, e; logic d, v, ed, ev; int lat, el, bn, pulses;
      @(negedge CLK);
      in_a = 64'd555555555; in_b = 32'd777; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (14) @(posedge CLK);
      @(negedge CLK); reset = 1'b1;
      @(posedge CLK); #1;
      n_total++;
      if ({out, out_valid, busy, dbz, ovf} !== 68'd0) $display("FAIL reset_mid got=%h req=0", {out, out_valid, busy, dbz, ovf});
      else n_pass++;
      @(negedge CLK); reset = 1'b0;
      pulses = 0;
      repeat (40) begin @(posedge CLK); #1; if (out_valid || busy) pulses++; end
      n_total++;
      if (pulses !== 0) $display("FAIL aborted_op_activity got=%0d req=0", pulses); else n_pass++;
      model(-64'sd123456789012, -32'sd98765, e, ed, ev, el);
      do_div(-64'sd123456789012, -32'sd98765, o, d, v, lat, bn);
      n_total++;
      if ({o, d, v} !== {e, ed, ev} || lat !== el) $display("FAIL after_reset got=%h lat=%0d req=%h lat=%0d", o, lat, e, el);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_dbz();
      test_overflow();
      test_roundtrip();
      test_random();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
